// File: rtl/seven_seg_if.sv
// Display-side bundle between a data producer and the seven-segment scan driver.
// The producer owns the load strobe and display data; the driver owns the pin-level outputs.
interface seven_seg_if #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BRIGHT_W   = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     blank_in;
    logic                      lz_en;
    logic [BRIGHT_W-1:0]       brightness;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_start;
    logic                      upd_pending;

    modport master (
        output load, digits_in, dp_in, blank_in, lz_en, brightness,
        input  seg, dp, an, frame_start, upd_pending
    );

    modport slave (
        input  load, digits_in, dp_in, blank_in, lz_en, brightness,
        output seg, dp, an, frame_start, upd_pending
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit seven-segment driver: hex decode, blanking, leading-zero suppression,
// PWM brightness and a shadow/active buffer pair swapped only at frame wrap.
module seven_seg_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BRIGHT_W    = 4,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    seven_seg_if.slave   bus
);
    localparam int unsigned SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned NIB_W  = 4 * NUM_DIGITS;
    localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] PWM_LAST  = BRIGHT_W'((1 << BRIGHT_W) - 2);

    // Scan position
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BRIGHT_W-1:0] pwm_q, pwm_d;
    logic                slot_last, frame_wrap;

    // Double buffer
    logic                pending_q, pending_d;
    logic [NIB_W-1:0]      sh_digits_q, act_digits_q;
    logic [NUM_DIGITS-1:0] sh_dp_q, act_dp_q;
    logic [NUM_DIGITS-1:0] sh_blank_q, act_blank_q;
    logic                  sh_lz_q, act_lz_q;

    // Registered pin outputs
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  fs_q;

    // Decode intermediates
    logic [NUM_DIGITS-1:0] lz_sup, dark;
    logic                  zero_run;
    logic [3:0]            cur_nib;
    logic                  cur_dark, cur_dp, lit;
    logic [6:0]            seg_c;
    logic                  dp_c, fs_c;
    logic [NUM_DIGITS-1:0] an_c;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_glyph = 7'b0111111;
            4'h1:    hex_glyph = 7'b0000110;
            4'h2:    hex_glyph = 7'b1011011;
            4'h3:    hex_glyph = 7'b1001111;
            4'h4:    hex_glyph = 7'b1100110;
            4'h5:    hex_glyph = 7'b1101101;
            4'h6:    hex_glyph = 7'b1111101;
            4'h7:    hex_glyph = 7'b0000111;
            4'h8:    hex_glyph = 7'b1111111;
            4'h9:    hex_glyph = 7'b1101111;
            4'hA:    hex_glyph = 7'b1110111;
            4'hB:    hex_glyph = 7'b1111100;
            4'hC:    hex_glyph = 7'b0111001;
            4'hD:    hex_glyph = 7'b1011110;
            4'hE:    hex_glyph = 7'b1111001;
            default: hex_glyph = 7'b1110001;
        endcase
    endfunction

    // Next scan position and pending flag; a load in the wrap cycle keeps pending set
    always_comb begin : next_state
        slot_last  = (slot_q == SLOT_LAST);
        frame_wrap = slot_last && (idx_q == IDX_LAST);
        slot_d     = slot_last ? '0 : slot_q + SLOT_W'(1);
        idx_d      = idx_q;
        if (slot_last) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        pwm_d     = (slot_last || (pwm_q == PWM_LAST)) ? '0 : pwm_q + BRIGHT_W'(1);
        pending_d = pending_q;
        if (bus.load) begin
            pending_d = 1'b1;
        end else if (frame_wrap) begin
            pending_d = 1'b0;
        end
    end

    // Digit darkening, glyph selection and PWM-gated anode for the current slot
    always_comb begin : decode
        zero_run = act_lz_q;
        lz_sup   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_digits_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
            if (i != 0) begin
                lz_sup[i] = zero_run;
            end
        end
        dark     = act_blank_q | lz_sup;
        cur_nib  = 4'h0;
        cur_dark = 1'b1;
        cur_dp   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib  = act_digits_q[4*i +: 4];
                cur_dark = dark[i];
                cur_dp   = act_dp_q[i];
            end
        end
        lit   = !cur_dark && (pwm_q < bus.brightness);
        seg_c = cur_dark ? 7'h00 : hex_glyph(cur_nib);
        dp_c  = !cur_dark && cur_dp;
        an_c  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_c[i] = lit && (idx_q == IDX_W'(i));
        end
        fs_c = (idx_q == '0) && (slot_q == '0);
    end

    always_ff @(posedge clk) begin : state_regs
        if (rst) begin
            slot_q       <= '0;
            idx_q        <= '0;
            pwm_q        <= '0;
            pending_q    <= 1'b0;
            sh_digits_q  <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '1;
            sh_lz_q      <= 1'b0;
            act_digits_q <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            act_lz_q     <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            idx_q     <= idx_d;
            pwm_q     <= pwm_d;
            pending_q <= pending_d;
            if (frame_wrap && pending_q) begin
                act_digits_q <= sh_digits_q;
                act_dp_q     <= sh_dp_q;
                act_blank_q  <= sh_blank_q;
                act_lz_q     <= sh_lz_q;
            end
            if (bus.load) begin
                sh_digits_q <= bus.digits_in;
                sh_dp_q     <= bus.dp_in;
                sh_blank_q  <= bus.blank_in;
                sh_lz_q     <= bus.lz_en;
            end
        end
    end

    // Pin registers; polarity applied here so the decode stays active-high
    always_ff @(posedge clk) begin : out_regs
        if (rst) begin
            seg_q <= {7{ACTIVE_LOW}};
            dp_q  <= ACTIVE_LOW;
            an_q  <= {NUM_DIGITS{ACTIVE_LOW}};
            fs_q  <= 1'b0;
        end else begin
            seg_q <= seg_c ^ {7{ACTIVE_LOW}};
            dp_q  <= dp_c ^ ACTIVE_LOW;
            an_q  <= an_c ^ {NUM_DIGITS{ACTIVE_LOW}};
            fs_q  <= fs_c;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.frame_start = fs_q;
    assign bus.upd_pending = pending_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver (4 digits, 4-cycle slots, 2-bit brightness, active-low pins):
// directed scenarios plus random traffic against a cycle-index reference model.
module tb_seven_seg_scan_driver;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BW = 2;
    localparam int PP = (1 << BW) - 1;
    localparam int FRAME = ND * RD;

    logic clk;
    logic rst;

    seven_seg_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bif ();

    seven_seg_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BRIGHT_W(BW), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: s counts cycles since reset; the scan position is pure arithmetic on s
    int          s;
    logic [15:0] m_sh_dig, m_act_dig;
    logic [3:0]  m_sh_dp, m_act_dp, m_sh_bl, m_act_bl;
    logic        m_sh_lz, m_act_lz, m_pend;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;
    logic [3:0]  e_an;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        s = 0; m_pend = 1'b0;
        m_sh_dig = '0; m_sh_dp = '0; m_sh_bl = '1; m_sh_lz = 1'b0;
        m_act_dig = '0; m_act_dp = '0; m_act_bl = '1; m_act_lz = 1'b0;
    endtask

    // One clock: predict from model + live inputs, advance model, clock DUT, compare
    task automatic step();
        int  idx, pw;
        logic dark, all0;
        logic [3:0] nib;
        if (rst) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fs = 1'b0;
            model_reset();
        end else begin
            idx  = (s / RD) % ND;
            pw   = (s % RD) % PP;
            nib  = m_act_dig[4*idx +: 4];
            dark = m_act_bl[idx];
            if (m_act_lz && idx != 0) begin
                all0 = 1'b1;
                for (int j = idx; j < ND; j++)
                    if (m_act_dig[4*j +: 4] != 4'h0 || m_act_dp[j]) all0 = 1'b0;
                dark = dark | all0;
            end
            e_seg = dark ? 7'h7F : ~glyph(nib);
            e_dp  = ~(!dark && m_act_dp[idx]);
            e_an  = (!dark && pw < int'(bif.brightness)) ? ~(4'b0001 << idx) : 4'hF;
            e_fs  = (s % FRAME) == 0;
            if ((s % FRAME) == FRAME - 1 && m_pend) begin
                m_act_dig = m_sh_dig; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl; m_act_lz = m_sh_lz;
                m_pend = 1'b0;
            end
            if (bif.load) begin
                m_sh_dig = bif.digits_in; m_sh_dp = bif.dp_in;
                m_sh_bl = bif.blank_in; m_sh_lz = bif.lz_en;
                m_pend = 1'b1;
            end
            s++;
        end
        @(posedge clk);
        #1;
        chk("seg", 32'(bif.seg), 32'(e_seg));
        chk("dp", 32'(bif.dp), 32'(e_dp));
        chk("an", 32'(bif.an), 32'(e_an));
        chk("frame_start", 32'(bif.frame_start), 32'(e_fs));
        chk("upd_pending", 32'(bif.upd_pending), 32'(m_pend));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv,
                           input logic [3:0] bl, input logic lz);
        bif.digits_in = d; bif.dp_in = dpv; bif.blank_in = bl; bif.lz_en = lz;
        bif.load = 1'b1;
        step();
        bif.load = 1'b0;
    endtask

    // Advance until a frame_start output cycle, bounded
    task automatic wait_frame();
        int i;
        for (i = 0; i < 3 * FRAME; i++) begin
            step();
            if (bif.frame_start === 1'b1) break;
        end
        chk("frame_timeout", 32'(i < 3 * FRAME), 32'd1);
    endtask

    initial begin
        bif.load = 1'b0; bif.digits_in = '0; bif.dp_in = '0; bif.blank_in = '0;
        bif.lz_en = 1'b0; bif.brightness = 2'd3;
        rst = 1'b1;
        model_reset();
        steps(2);
        chk("rst_an", 32'(bif.an), 32'hF);
        chk("rst_seg", 32'(bif.seg), 32'h7F);
        chk("rst_upd", 32'(bif.upd_pending), 32'd0);
        rst = 1'b0;

        // 0x1234 appears at the next frame, digit by digit
        do_load(16'h1234, 4'h0, 4'h0, 1'b0);
        chk("load_pending", 32'(bif.upd_pending), 32'd1);
        wait_frame();
        chk("d0_an", 32'(bif.an), 32'b1110);
        chk("d0_seg", 32'(bif.seg), 32'b0011001);
        chk("applied_upd", 32'(bif.upd_pending), 32'd0);
        steps(4);
        chk("d1_an", 32'(bif.an), 32'b1101);
        chk("d1_seg", 32'(bif.seg), 32'h30);
        steps(4);
        chk("d2_an", 32'(bif.an), 32'b1011);
        chk("d2_seg", 32'(bif.seg), 32'h24);
        steps(4);
        chk("d3_an", 32'(bif.an), 32'b0111);
        chk("d3_seg", 32'(bif.seg), 32'b1111001);

        // Leading-zero suppression on 0x0050
        do_load(16'h0050, 4'h0, 4'h0, 1'b1);
        wait_frame();
        chk("lz_d0_seg", 32'(bif.seg), 32'h40);
        steps(4);
        chk("lz_d1_seg", 32'(bif.seg), 32'h12);
        steps(4);
        chk("lz_d2_an", 32'(bif.an), 32'hF);
        chk("lz_d2_seg", 32'(bif.seg), 32'h7F);
        steps(4);
        chk("lz_d3_an", 32'(bif.an), 32'hF);

        // A decimal point stops suppression at its digit
        do_load(16'h0050, 4'b0100, 4'h0, 1'b1);
        wait_frame();
        steps(8);
        chk("lzdp_d2_an", 32'(bif.an), 32'b1011);
        chk("lzdp_d2_seg", 32'(bif.seg), 32'h40);
        chk("lzdp_d2_dp", 32'(bif.dp), 32'd0);
        steps(4);
        chk("lzdp_d3_an", 32'(bif.an), 32'hF);
        chk("lzdp_d3_dp", 32'(bif.dp), 32'd1);

        // Two loads in one frame: last wins, nothing changes until wrap
        steps(2);
        do_load(16'h1111, 4'h0, 4'h0, 1'b0);
        steps(1);
        do_load(16'h2222, 4'h0, 4'h0, 1'b0);
        chk("dbl_pending", 32'(bif.upd_pending), 32'd1);
        wait_frame();
        chk("dbl_seg", 32'(bif.seg), 32'h24);
        chk("dbl_upd", 32'(bif.upd_pending), 32'd0);

        // Load landing exactly in the wrap cycle waits a full extra frame
        while ((s % FRAME) != FRAME - 1) step();
        do_load(16'h3333, 4'h0, 4'h0, 1'b0);
        wait_frame();
        chk("wrapload_old", 32'(bif.seg), 32'h24);
        chk("wrapload_pend", 32'(bif.upd_pending), 32'd1);
        wait_frame();
        chk("wrapload_new", 32'(bif.seg), 32'h30);

        // Brightness: code 1 lights pwm phase 0 only, code 0 never
        bif.brightness = 2'd1;
        wait_frame();
        chk("br1_p0", 32'(bif.an), 32'b1110);
        step();
        chk("br1_p1", 32'(bif.an), 32'hF);
        steps(2);
        chk("br1_p3", 32'(bif.an), 32'b1110);
        bif.brightness = 2'd0;
        steps(3);
        chk("br0", 32'(bif.an), 32'hF);
        bif.brightness = 2'd3;

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            int r;
            logic [15:0] d;
            r = int'($urandom_range(0, 99));
            rst = (r < 2);
            if (r >= 2 && r < 10) begin
                d = 16'($urandom) >> (4 * $urandom_range(0, 4));
                bif.digits_in = d;
                bif.dp_in     = 4'($urandom & $urandom & $urandom);
                bif.blank_in  = 4'($urandom & $urandom);
                bif.lz_en     = 1'($urandom);
                bif.load      = 1'b1;
            end else begin
                bif.load = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) bif.brightness = 2'($urandom);
            step();
        end
        rst = 1'b0; bif.load = 1'b0; bif.brightness = 2'd3;

        // Mid-frame reset with an update pending discards everything
        wait_frame();
        steps(3);
        do_load(16'h8888, 4'hF, 4'h0, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("mrst_an", 32'(bif.an), 32'hF);
        chk("mrst_seg", 32'(bif.seg), 32'h7F);
        chk("mrst_upd", 32'(bif.upd_pending), 32'd0);
        rst = 1'b0;
        wait_frame();
        steps(5);
        chk("mrst_dark", 32'(bif.an), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
